// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multi-cycle sequencer (master) and the shared datapath (slave).
interface multicycle_ctrl_fsm_if #(
    parameter int unsigned CNT_W = 16
);
    // Datapath status into the sequencer
    logic [3:0]       opcode;
    logic             zero_flag;
    logic             mem_ready;

    // Sequencer controls out to the datapath
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             ir_write;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic             reg_write;
    logic             wb_sel;
    logic             alu_src_b;
    logic [3:0]       alu_op;
    logic             halted;
    logic             illegal;
    logic [2:0]       state_out;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, zero_flag, mem_ready,
        output pc_write, pc_src, ir_write, mem_req, mem_we, mem_addr_sel, reg_write, wb_sel,
               alu_src_b, alu_op, halted, illegal, state_out, retired
    );

    modport slave (
        output opcode, zero_flag, mem_ready,
        input  pc_write, pc_src, ir_write, mem_req, mem_we, mem_addr_sel, reg_write, wb_sel,
               alu_src_b, alu_op, halted, illegal, state_out, retired
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the 16-bit RISC core.
// Steps the datapath through FETCH / DECODE / EXEC / MEM / WB and counts retired instructions.
// Optional feature macro ILLEGAL_TRAP_EN: when defined, illegal opcodes enter a sticky TRAP
// state; when undefined they execute as a 3-cycle NOP and illegal is tied 0.
module multicycle_ctrl_fsm #(
    parameter int unsigned CNT_W    = 16,
    parameter logic [3:0]  HALT_OPC = 4'b1111
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_ctrl_fsm_if.master bus
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5,
        StTrap   = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    // Opcode classes; opcode is stable from DECODE onward
    logic is_rtype, is_lw, is_sw, is_beq, is_jmp, is_halt, is_legal;

    assign is_rtype = (bus.opcode[3:2] == 2'b00);
    assign is_lw    = (bus.opcode == 4'b0100);
    assign is_sw    = (bus.opcode == 4'b0101);
    assign is_beq   = (bus.opcode == 4'b0110);
    assign is_jmp   = (bus.opcode == 4'b0111);
    assign is_halt  = (bus.opcode == HALT_OPC);
    assign is_legal = is_rtype | is_lw | is_sw | is_beq | is_jmp;

    // An instruction retires on the edge that returns the FSM to FETCH from EXEC/MEM/WB
    assign retire = (state_d == StFetch) &&
                    ((state_q == StExec) || (state_q == StMem) || (state_q == StWb));

    // State register and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (bus.mem_ready) state_d = StDecode;
            end
            StDecode: begin
                if (is_halt) begin
                    state_d = StHalt;
`ifdef ILLEGAL_TRAP_EN
                end else if (!is_legal) begin
                    state_d = StTrap;
`endif
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_rtype)           state_d = StWb;
                else if (is_lw || is_sw) state_d = StMem;
                else                    state_d = StFetch;
            end
            StMem: begin
                if (bus.mem_ready) state_d = is_sw ? StFetch : StWb;
            end
            StWb:   state_d = StFetch;
            StHalt: state_d = StHalt;
`ifdef ILLEGAL_TRAP_EN
            StTrap: state_d = StTrap;
`endif
            default: state_d = StFetch;
        endcase
    end

    // Control outputs; only FETCH ir/pc writes and the BEQ pc_write look at live inputs
    always_comb begin
        bus.pc_write     = 1'b0;
        bus.pc_src       = 2'b00;
        bus.ir_write     = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.reg_write    = 1'b0;
        bus.wb_sel       = 1'b0;
        bus.alu_src_b    = 1'b0;
        bus.alu_op       = 4'b0000;
        bus.halted       = 1'b0;
        bus.illegal      = 1'b0;
        // Reset drops everything immediately, including an in-flight mem_req
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    bus.mem_req  = 1'b1;
                    bus.ir_write = bus.mem_ready;
                    bus.pc_write = bus.mem_ready;
                end
                StExec: begin
                    if (is_rtype) begin
                        bus.alu_op = bus.opcode;
                    end else if (is_lw || is_sw) begin
                        bus.alu_src_b = 1'b1;
                    end else if (is_beq) begin
                        bus.alu_op   = 4'b0001;
                        bus.pc_src   = 2'b01;
                        bus.pc_write = bus.zero_flag;
                    end else if (is_jmp) begin
                        bus.pc_src   = 2'b10;
                        bus.pc_write = 1'b1;
                    end
                end
                StMem: begin
                    bus.mem_req      = 1'b1;
                    bus.mem_addr_sel = 1'b1;
                    bus.mem_we       = is_sw;
                end
                StWb: begin
                    bus.reg_write = 1'b1;
                    bus.wb_sel    = is_lw;
                end
                StHalt: begin
                    bus.halted = 1'b1;
                end
`ifdef ILLEGAL_TRAP_EN
                StTrap: begin
                    bus.halted  = 1'b1;
                    bus.illegal = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.state_out = state_q;
    assign bus.retired   = retired_q;

endmodule
